mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit for the pipelined OTTER; consumes the memory-control fields carried down the pipeline registers (MemWrite, MemSign, MemSize, address, store data) at the M stage.
- Drives a single-outstanding request/acknowledge data-memory bus.
- Performs byte-lane alignment and load extension.
- Stalls the pipeline until each access completes.

---
 rtl/otter_mem_pkg.sv | 6 +
 rtl/lsu_lane_align.sv | 28 ++
 rtl/mem_stage_lsu.sv | 115 +++++++++++
 tb/tb_mem_stage_lsu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/otter_mem_pkg.sv
// otter_mem_pkg: shared types and constants for the OTTER memory stage
package otter_mem_pkg;
  localparam int MEM_ADDR_W = 32;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} mem_size_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-lane placement and load extract/extend
module lsu_lane_align
  import otter_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_uns,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    be = st_size == SZ_BYTE ? 4'b0001 << st_off :
         st_size == SZ_HALF ? (st_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = st_size == SZ_BYTE ? {4{st_data[7:0]}} :
            st_size == SZ_HALF ? {2{st_data[15:0]}} : st_data;
    b = ld_word[{ld_off, 3'b000} +: 8];
    h = ld_word[{ld_off[1], 4'b0000} +: 16];
    ld_data = ld_size == SZ_BYTE ? {{24{~ld_uns & b[7]}}, b} :
              ld_size == SZ_HALF ? {{16{~ld_uns & h[15]}}, h} : ld_word;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit driving a single-outstanding req/ack data bus
module mem_stage_lsu
  import otter_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic                  MemSignM,
  input  logic [1:0]            MemSizeM,
  input  logic [MEM_ADDR_W-1:0] ALUResultM,
  input  logic [31:0]           WriteDataM,
  output logic [31:0]           ReadDataM,
  output logic                  StallM,
  output logic                  AccessErrM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  lsu_state_t state_q, state_d;
  logic we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, st_wdata, ld_data;
  logic [3:0] be_q, be_d, st_be;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [15:0] cnt_q, cnt_d;
  logic acc, bad, start;
  lsu_lane_align u_align (
    .st_size(MemSizeM), .st_off(ALUResultM[1:0]), .st_data(WriteDataM),
    .ld_size(size_q), .ld_off(off_q), .ld_uns(sign_q), .ld_word(mem_rdata),
    .be(st_be), .wdata(st_wdata), .ld_data(ld_data)
  );
  always_comb begin
    acc = MemReadM | MemWriteM;
    bad = MemSizeM == SZ_ILL || (MemSizeM == SZ_HALF && ALUResultM[0]) ||
          (MemSizeM == SZ_WORD && |ALUResultM[1:0]) || (MemReadM && MemWriteM);
    start = state_q == IDLE && acc && !bad;
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    size_d = size_q;
    sign_d = sign_q;
    off_d = off_q;
    rdata_d = rdata_q;
    cnt_d = '0;
    err_d = 1'b0;
    if (start) begin
      state_d = REQ;
      we_d = MemWriteM;
      addr_d = {ALUResultM[MEM_ADDR_W-1:2], 2'b00};
      wdata_d = st_wdata;
      be_d = st_be;
      size_d = MemSizeM;
      sign_d = MemSignM;
      off_d = ALUResultM[1:0];
    end else if (state_q == REQ) begin
      if (mem_ack) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : ld_data;
      end else if (cnt_q == TO_LAST) begin
        state_d = DONE;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      size_q <= '0;
      sign_q <= 1'b0;
      off_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      size_q <= size_d;
      sign_q <= sign_d;
      off_q <= off_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // Gating with RST keeps the combinational flags quiet while held in reset
  assign StallM = !RST && (start || state_q == REQ);
  assign AccessErrM = !RST && (err_q || (state_q == IDLE && acc && bad));
  assign mem_req = state_q == REQ;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be = be_q;
  assign ReadDataM = rdata_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and random checks of mem_stage_lsu against a transaction-level model
module tb_mem_stage_lsu;
  localparam int TO = 4;
  logic CLK = 1'b0, RST = 1'b1;
  logic MemReadM = 0, MemWriteM = 0, MemSignM = 0, mem_ack = 0;
  logic [1:0] MemSizeM = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0, mem_rdata = 0;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic StallM, AccessErrM, mem_req, mem_we;
  logic [3:0] mem_be;
  int n_chk = 0, n_err = 0;
  logic [31:0] exp_rd = 0;

  always #5 CLK = ~CLK;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemSignM(MemSignM), .MemSizeM(MemSizeM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .AccessErrM(AccessErrM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [1:0] sz, input int unsigned a,
                                           input logic uns, input logic [31:0] w);
    int unsigned v;
    v = w;
    if (sz == 0) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> (16 * (a / 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One pipeline instruction in M: ackd = REQ cycle of the ack, 0 = never acked
  task automatic access(input logic rd, input logic wr, input logic sg, input logic [1:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rdv,
                        input int ackd);
    int unsigned a;
    bit bad, go, timed;
    logic [3:0] ebe;
    logic [31:0] ewd;
    a = ad[1:0];
    bad = (rd || wr) && (sz == 3 || (sz == 1 && a % 2 == 1) || (sz == 2 && a != 0) || (rd && wr));
    go = (rd || wr) && !bad;
    timed = (ackd == 0);
    ebe = sz == 0 ? 4'(1 << a) : sz == 1 ? (a == 0 ? 4'h3 : 4'hC) : 4'hF;
    ewd = sz == 0 ? wd[7:0] * 32'h0101_0101 : sz == 1 ? wd[15:0] * 32'h0001_0001 : wd;
    @(posedge CLK); #1;
    MemReadM = rd; MemWriteM = wr; MemSignM = sg; MemSizeM = sz;
    ALUResultM = ad; WriteDataM = wd;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    #1;
    chk("idle_stall", StallM, go);
    chk("idle_err", AccessErrM, bad);
    chk("idle_req", mem_req, 0);
    if (go) begin
      for (int n = 1; n <= TO; n++) begin
        @(posedge CLK); #1;
        MemReadM = 1'($urandom); MemWriteM = 1'($urandom); WriteDataM = $urandom;
        mem_ack = (n == ackd);
        mem_rdata = (n == ackd) ? rdv : $urandom;
        #1;
        chk("req_req", mem_req, 1);
        chk("req_stall", StallM, 1);
        chk("req_err", AccessErrM, 0);
        chk("req_we", mem_we, wr);
        chk("req_addr", mem_addr, ad & 32'hFFFF_FFFC);
        chk("req_be", mem_be, ebe);
        chk("req_wdata", mem_wdata, ewd);
        if (n == ackd) break;
      end
      if (!timed && !wr) exp_rd = load_val(sz, a, sg, rdv);
      @(posedge CLK); #1;
      mem_ack = 1'($urandom); MemReadM = 0; MemWriteM = 0;
      #1;
      chk("done_stall", StallM, 0);
      chk("done_req", mem_req, 0);
      chk("done_err", AccessErrM, timed);
    end
    @(posedge CLK); #1;
    mem_ack = 0; MemReadM = 0; MemWriteM = 0;
    #1;
    chk("after_stall", StallM, 0);
    chk("after_err", AccessErrM, 0);
    chk("after_req", mem_req, 0);
    chk("read_data", ReadDataM, exp_rd);
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] ad;
    int k;
    #1;
    chk("rst_rd", ReadDataM, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_err", AccessErrM, 0);
    chk("rst_be", mem_be, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    access(0, 1, 0, 2, 32'h1000, 32'hDEADBEEF, 0, 3);
    access(0, 1, 0, 0, 32'h2003, 32'h000000A5, 0, 1);
    access(1, 0, 0, 0, 32'h3001, 0, 32'h00008000, 1);
    chk("lb_signed", ReadDataM, 32'hFFFFFF80);
    access(1, 0, 1, 0, 32'h3001, 0, 32'h00008000, 2);
    chk("lbu", ReadDataM, 32'h00000080);
    access(1, 0, 0, 1, 32'h3002, 0, 32'h80010000, 1);
    chk("lh_signed", ReadDataM, 32'hFFFF8001);
    access(1, 0, 0, 2, 32'h4002, 0, 0, 1);
    access(1, 0, 0, 3, 32'h4000, 0, 0, 1);
    access(1, 1, 0, 2, 32'h4000, 0, 0, 1);
    access(0, 1, 0, 1, 32'h4001, 32'h1234, 0, 1);
    access(1, 0, 0, 2, 32'h5000, 0, 32'h13572468, 0);
    chk("timeout_hold", ReadDataM, 32'hFFFF8001);
    access(0, 1, 0, 2, 32'h5004, 32'h1, 0, TO);
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      sz = 2'($urandom);
      ad = $urandom;
      if ($urandom_range(0, 2) != 0) ad[1:0] = sz == 0 ? ad[1:0] : sz == 1 ? {ad[1], 1'b0} : 2'b00;
      access(k < 5 || k == 9, k >= 5 && k != 8 ? 1'b1 : (k == 9), 1'($urandom), sz, ad,
             $urandom, $urandom, $urandom_range(0, TO));
    end
    access(1, 0, 0, 2, 32'h6000, 0, 32'hCAFEF00D, 1);
    @(posedge CLK); #1;
    MemReadM = 1; MemSizeM = 2; ALUResultM = 32'h10;
    @(posedge CLK); #1;
    chk("pre_rst_req", mem_req, 1);
    #2 RST = 1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_stall", StallM, 0);
    chk("arst_rd", ReadDataM, 0);
    chk("arst_err", AccessErrM, 0);
    exp_rd = 0;
    MemReadM = 0;
    @(posedge CLK); #1 RST = 0;
    access(1, 0, 0, 2, 32'h0, 0, 32'h89ABCDEF, 1);
    chk("post_rst_lw", ReadDataM, 32'h89ABCDEF);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
